// File: rtl/ct_prio_req_buf_pkg.sv
// Shared types and helpers for the ct_prio requester-side buffer.
// Vector helpers operate on a fixed MaxNum-wide view; callers zero-extend.
package ct_prio_req_buf_pkg;

  localparam int unsigned MaxNum = 32;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } lock_st_e;

  function automatic int unsigned onehot_to_bin(input logic [MaxNum-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxNum; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

  // Index of the lowest clear bit; MaxNum if none (only used when not full).
  function automatic int unsigned first_zero(input logic [MaxNum-1:0] v);
    int unsigned idx;
    idx = MaxNum;
    for (int i = MaxNum - 1; i >= 0; i--) begin
      if (!v[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ct_prio_req_buf_entry.sv
// One buffer slot: payload register loaded on write enable.
// Payload deliberately has no reset; validity is tracked by the parent.
module ct_prio_req_buf_entry #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) data_q <= data_i;
  end

  assign data_o = data_q;

endmodule

// File: rtl/ct_prio_req_buf.sv
// Request buffer feeding the ct_prio matrix arbiter; presents the granted entry
// downstream and pins the grant while the consumer stalls.
module ct_prio_req_buf
  import ct_prio_req_buf_pkg::*;
#(
  parameter int unsigned Num   = 4,
  parameter int unsigned Width = 64,
  localparam int unsigned CntW = $clog2(Num + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_vld_i,
  input  logic [Width-1:0] in_data_i,
  output logic             in_rdy_o,
  output logic [Num-1:0]   arb_valid_o,
  input  logic [Num-1:0]   arb_sel_i,
  output logic             arb_clr_o,
  output logic             out_vld_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_rdy_i,
  output logic [CntW-1:0]  entry_cnt_o
);

  localparam int unsigned IdxW = $clog2(Num);

  logic [Num-1:0]  entry_vld_q, entry_vld_d;
  lock_st_e        lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic             enq;
  logic [IdxW-1:0]  alloc_idx;
  logic [IdxW-1:0]  sel_idx;
  logic [Num-1:0]   hit;
  logic [Width-1:0] payload [Num];

  assign in_rdy_o  = ~&entry_vld_q & ~flush_i;
  assign enq       = in_vld_i & in_rdy_o;
  assign alloc_idx = IdxW'(first_zero(MaxNum'(entry_vld_q)));
  assign sel_idx   = IdxW'(onehot_to_bin(MaxNum'(arb_sel_i)));

  // Grants on empty entries are ignored.
  assign hit       = arb_sel_i & entry_vld_q;
  assign out_vld_o = |hit & ~flush_i;
  assign arb_clr_o = out_vld_o & out_rdy_i;

  assign arb_valid_o = (lock_q == StHold) ? (Num'(1) << lock_idx_q) : entry_vld_q;
  assign entry_cnt_o = cnt_q;

  for (genvar i = 0; i < Num; i++) begin : g_entry
    ct_prio_req_buf_entry #(
      .Width(Width)
    ) u_entry (
      .clk_i (clk_i),
      .we_i  (enq && (alloc_idx == IdxW'(i))),
      .data_i(in_data_i),
      .data_o(payload[i])
    );
  end

  always_comb begin
    out_data_o = '0;
    for (int unsigned i = 0; i < Num; i++) begin
      out_data_o = out_data_o | ({Width{arb_sel_i[i]}} & payload[i]);
    end
  end

  always_comb begin
    entry_vld_d = entry_vld_q;
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    cnt_d       = cnt_q;
    if (flush_i) begin
      entry_vld_d = '0;
      lock_d      = StIdle;
      cnt_d       = '0;
    end else begin
      if (arb_clr_o) entry_vld_d = entry_vld_d & ~hit;
      if (enq) entry_vld_d[alloc_idx] = 1'b1;
      unique case ({enq, arb_clr_o})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
      unique case (lock_q)
        StIdle: begin
          if (out_vld_o && !out_rdy_i) begin
            lock_d     = StHold;
            lock_idx_d = sel_idx;
          end
        end
        StHold: begin
          if (out_rdy_i) lock_d = StIdle;
        end
        default: lock_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_vld_q <= '0;
      lock_q      <= StIdle;
      lock_idx_q  <= '0;
      cnt_q       <= '0;
    end else begin
      entry_vld_q <= entry_vld_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      cnt_q       <= cnt_d;
    end
  end

  sel_onehot0_a: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(arb_sel_i));

endmodule

// File: tb/tb_ct_prio_req_buf.sv
// Bench for ct_prio_req_buf with a behavioural LRU matrix arbiter alongside and a
// slot-level reference model checked every cycle.
module tb_ct_prio_req_buf;

  localparam int unsigned NUM   = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = $clog2(NUM + 1);

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             flush;
  logic             in_vld;
  logic [WIDTH-1:0] in_data;
  logic             in_rdy;
  logic [NUM-1:0]   arb_valid;
  logic [NUM-1:0]   arb_sel;
  logic [NUM-1:0]   arb_grant;
  logic             arb_clr;
  logic             out_vld;
  logic [WIDTH-1:0] out_data;
  logic             out_rdy;
  logic [CW-1:0]    entry_cnt;

  logic             sel_force_en;
  logic [NUM-1:0]   sel_force;

  always #5 clk = ~clk;

  ct_prio_req_buf #(
    .Num  (NUM),
    .Width(WIDTH)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .flush_i    (flush),
    .in_vld_i   (in_vld),
    .in_data_i  (in_data),
    .in_rdy_o   (in_rdy),
    .arb_valid_o(arb_valid),
    .arb_sel_i  (arb_sel),
    .arb_clr_o  (arb_clr),
    .out_vld_o  (out_vld),
    .out_data_o (out_data),
    .out_rdy_i  (out_rdy),
    .entry_cnt_o(entry_cnt)
  );

  // Stand-in for ct_prio: least-recently-granted matrix, index order after reset.
  logic [NUM-1:0] beats [NUM];

  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      arb_grant[i] = arb_valid[i];
      for (int j = 0; j < NUM; j++) begin
        if (j != i && arb_valid[j] && !beats[i][j]) arb_grant[i] = 1'b0;
      end
    end
    arb_sel = sel_force_en ? sel_force : arb_grant;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM; i++)
        for (int j = 0; j < NUM; j++) beats[i][j] <= (i < j);
    end else if (arb_clr) begin
      for (int i = 0; i < NUM; i++) begin
        if (arb_sel[i]) begin
          for (int j = 0; j < NUM; j++) begin
            if (j != i) begin
              beats[i][j] <= 1'b0;
              beats[j][i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Reference model: which slots hold what, plus whether the grant is pinned.
  bit               m_vld  [NUM];
  logic [WIDTH-1:0] m_data [NUM];
  bit               m_lock;
  int               m_lock_i;
  bit               prev_stall;
  logic [WIDTH-1:0] prev_data;

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) m_vld[i] = 1'b0;
    m_lock     = 1'b0;
    m_lock_i   = 0;
    prev_stall = 1'b0;
  endtask

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    int             g, free, cnt;
    bit             full, exp_rdy, exp_ov, exp_clr;
    logic [NUM-1:0] exp_av;
    @(negedge clk);
    in_vld = v; in_data = d; out_rdy = r; flush = f;
    #1;
    full = 1'b1; cnt = 0; free = -1; g = -1;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (!m_vld[i]) begin full = 1'b0; free = i; end
      else cnt++;
      exp_av[i] = m_lock ? (i == m_lock_i) : m_vld[i];
      if (arb_sel[i] && m_vld[i]) g = i;
    end
    exp_rdy = !full && !f;
    exp_ov  = (g >= 0) && !f;
    exp_clr = exp_ov && r;
    check("in_rdy", 32'(in_rdy), 32'(exp_rdy));
    check("arb_valid", 32'(arb_valid), 32'(exp_av));
    check("out_vld", 32'(out_vld), 32'(exp_ov));
    check("arb_clr", 32'(arb_clr), 32'(exp_clr));
    check("entry_cnt", 32'(entry_cnt), cnt);
    if (exp_ov) check("out_data", 32'(out_data), 32'(m_data[g]));
    if (prev_stall && !f) begin
      check("stall_vld", 32'(out_vld), 32'd1);
      check("stall_data", 32'(out_data), 32'(prev_data));
    end
    prev_stall = exp_ov && !r;
    if (exp_ov) prev_data = m_data[g];
    if (f) begin
      for (int i = 0; i < NUM; i++) m_vld[i] = 1'b0;
      m_lock = 1'b0;
    end else begin
      if (exp_clr) m_vld[g] = 1'b0;
      if (v && exp_rdy) begin
        m_vld[free]  = 1'b1;
        m_data[free] = d;
      end
      if (!m_lock && exp_ov && !r) begin
        m_lock   = 1'b1;
        m_lock_i = g;
      end else if (m_lock && r) begin
        m_lock = 1'b0;
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_arb_valid", 32'(arb_valid), 32'd0);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_arb_clr", 32'(arb_clr), 32'd0);
    check("rst_entry_cnt", 32'(entry_cnt), 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0; flush = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    sel_force_en = 1'b0; sel_force = '0;
    model_reset();
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    // Fill all four, then drain in order.
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    step(1'b1, 8'hD4, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Grant on an empty slot must not raise out_vld.
    sel_force_en = 1'b1; sel_force = 4'b0001;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    sel_force_en = 1'b0;

    // Stall lock on entry 2 while entry 0 refills.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Full with simultaneous dequeue; freed slot usable next cycle.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Two entries, enqueue and dequeue together.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Flush while holding three entries.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 39) == 0));
    end

    // Asynchronous reset mid-transfer, then restart at entry 0.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    in_vld = 1'b0; out_rdy = 1'b0; flush = 1'b0;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    step(1'b1, 8'hC0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
